// File: rtl/host_mem_if_pkg.sv
// Shared definitions for the host memory line interface and its arbiter.
// The op encoding is also used by mem_arb.
package mem_if_pkg;

    localparam int LINE_SIZE = 512;
    localparam int BEAT_SIZE = 64;
    localparam int BEATS     = 8;
    localparam int BEAT_W    = 3;
    localparam int ADDR_W    = 32;

    typedef enum logic [1:0] {
        OP_NONE  = 2'b00,
        OP_READ  = 2'b01,
        OP_WRITE = 2'b10,
        OP_RSVD  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        IDLE,
        RD_REQ,
        RD_RESP,
        WR_REQ,
        DONE,
        REARM
    } state_e;

    // The reserved encoding behaves exactly like NONE.
    function automatic logic op_is_xfer(op_e o);
        return (o == OP_READ) || (o == OP_WRITE);
    endfunction

endpackage

// File: rtl/host_mem_if_if.sv
// Host-side beat bus: one request channel (addr/we/wdata) and one read-data return.
interface host_bus_if;
    import mem_if_pkg::*;

    logic                 host_req_valid;
    logic                 host_req_ready;
    logic                 host_req_we;
    logic [ADDR_W-1:0]    host_req_addr;
    logic [BEAT_SIZE-1:0] host_wdata;
    logic                 host_rvalid;
    logic [BEAT_SIZE-1:0] host_rdata;

    modport master (
        output host_req_valid, host_req_we, host_req_addr, host_wdata,
        input  host_req_ready, host_rvalid, host_rdata
    );

    modport slave (
        input  host_req_valid, host_req_we, host_req_addr, host_wdata,
        output host_req_ready, host_rvalid, host_rdata
    );

endinterface

// File: rtl/host_mem_if.sv
// Splits 512-bit line reads/writes from mem_arb into eight ascending 64-bit host beats
// and reassembles read lines.
module host_mem_if
    import mem_if_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           op,
    input  logic [ADDR_W-1:0]    io_addr,
    input  logic [LINE_SIZE-1:0] common_data_bus_out,
    output logic [LINE_SIZE-1:0] common_data_bus_in,
    output logic                 tx_done,
    output logic                 rd_valid,
    host_bus_if.master           host
);

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    state_e                 state_q, state_d;
    logic [BEAT_W-1:0]      beat_q, beat_d;
    logic [ADDR_W-7:0]      line_addr_q, line_addr_d;
    logic [LINE_SIZE-1:0]   line_q, line_d;
    logic [LINE_SIZE-1:0]   rd_line_q, rd_line_d;
    logic                   is_read_q, is_read_d;

    op_e        op_in;
    logic [8:0] beat_lsb;
    logic       unused_addr_bits;

    assign op_in            = op_e'(op);
    assign beat_lsb         = {beat_q, 6'd0};
    assign unused_addr_bits = ^io_addr[5:0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            beat_q      <= '0;
            line_addr_q <= '0;
            line_q      <= '0;
            rd_line_q   <= '0;
            is_read_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            line_addr_q <= line_addr_d;
            line_q      <= line_d;
            rd_line_q   <= rd_line_d;
            is_read_q   <= is_read_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        line_addr_d = line_addr_q;
        line_d      = line_q;
        rd_line_d   = rd_line_q;
        is_read_d   = is_read_q;

        host.host_req_valid = 1'b0;
        host.host_req_we    = 1'b0;
        tx_done             = 1'b0;
        rd_valid            = 1'b0;

        case (state_q)
            IDLE: begin
                if (op_is_xfer(op_in)) begin
                    line_addr_d = io_addr[ADDR_W-1:6];
                    beat_d      = '0;
                    is_read_d   = (op_in == OP_READ);
                    if (op_in == OP_WRITE) begin
                        line_d  = common_data_bus_out;
                        state_d = WR_REQ;
                    end else begin
                        state_d = RD_REQ;
                    end
                end
            end
            RD_REQ: begin
                host.host_req_valid = 1'b1;
                if (host.host_req_ready) state_d = RD_RESP;
            end
            RD_RESP: begin
                if (host.host_rvalid) begin
                    line_d[beat_lsb +: BEAT_SIZE] = host.host_rdata;
                    if (beat_q == LAST_BEAT) begin
                        // Publish the finished line in the same edge so it is
                        // already on the bus while rd_valid pulses.
                        rd_line_d = line_d;
                        state_d   = DONE;
                    end else begin
                        beat_d  = beat_q + 3'd1;
                        state_d = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                host.host_req_valid = 1'b1;
                host.host_req_we    = 1'b1;
                if (host.host_req_ready) begin
                    if (beat_q == LAST_BEAT) state_d = DONE;
                    else                     beat_d  = beat_q + 3'd1;
                end
            end
            DONE: begin
                tx_done  = 1'b1;
                rd_valid = is_read_q;
                state_d  = REARM;
            end
            REARM: begin
                if (!op_is_xfer(op_in)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign host.host_req_addr = {line_addr_q, beat_q, 3'b000};
    assign host.host_wdata    = line_q[beat_lsb +: BEAT_SIZE];
    assign common_data_bus_in = rd_line_q;

endmodule
